// File: rtl/div_16_8_seq.sv
// div_16_8_seq: sequential signed 16/8 restoring divider, one quotient bit per clock.
// Quotient truncates toward zero; remainder takes the sign of the dividend.
// Optional macro DIV_SAT_EN: saturate -32768 / -1 to 16'h7FFF and raise ovf
// (otherwise the quotient wraps to 16'h8000 and ovf stays 0).
module div_16_8_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] A_NUM,
  input  logic [7:0]  B_NUM,
  output logic [15:0] Q_NUM,
  output logic [7:0]  R_NUM,
  output logic        busy,
  output logic        done,
  output logic        dz,
  output logic        ovf
);

  localparam int unsigned ITERS = 16;

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t      state;
  logic [15:0] dvd;      // dividend magnitude, shifted left as quotient bits enter at the bottom
  logic [8:0]  b_mag;    // |B|, 9 bits so that -128 maps to 128
  logic [7:0]  rem;      // remainder magnitude; always < |B| <= 128
  logic [4:0]  cnt;
  logic        sign_q;
  logic        sign_r;
  logic        dz_pend;
  logic [7:0]  a_lo;

  logic [15:0] a_mag_c;
  logic [8:0]  b_ext_c;
  logic [8:0]  b_mag_c;
  logic [8:0]  shift_c;
  logic        ge_c;
  logic [7:0]  diff_c;
  logic [15:0] q_neg_c;
  logic [7:0]  r_neg_c;
`ifdef DIV_SAT_EN
  logic        ovf_c;
`endif

  // Operand magnitudes, trial subtraction and sign fix-up values
  always_comb begin
    a_mag_c = A_NUM[15] ? (~A_NUM + 16'd1) : A_NUM;
    b_ext_c = {B_NUM[7], B_NUM};
    b_mag_c = B_NUM[7] ? (~b_ext_c + 9'd1) : b_ext_c;
    // 9-bit partial remainder: previous remainder with the next dividend bit shifted in
    shift_c = {rem, dvd[15]};
    ge_c    = (shift_c >= b_mag);
    diff_c  = 8'(shift_c - b_mag);
    q_neg_c = ~dvd + 16'd1;
    r_neg_c = ~rem + 8'd1;
`ifdef DIV_SAT_EN
    // Only -32768 / -1 yields a positive quotient with bit 15 set
    ovf_c   = ~sign_q & dvd[15];
`endif
  end

  // Control FSM, datapath registers and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      dvd     <= '0;
      b_mag   <= '0;
      rem     <= '0;
      cnt     <= '0;
      sign_q  <= 1'b0;
      sign_r  <= 1'b0;
      dz_pend <= 1'b0;
      a_lo    <= '0;
      Q_NUM   <= '0;
      R_NUM   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      dz      <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            dvd     <= a_mag_c;
            b_mag   <= b_mag_c;
            rem     <= '0;
            cnt     <= '0;
            sign_q  <= A_NUM[15] ^ B_NUM[7];
            sign_r  <= A_NUM[15];
            a_lo    <= A_NUM[7:0];
            dz_pend <= (B_NUM == 8'd0);
            busy    <= 1'b1;
            state   <= (B_NUM == 8'd0) ? FIX : CALC;
          end
        end
        CALC: begin
          rem <= ge_c ? diff_c : shift_c[7:0];
          dvd <= {dvd[14:0], ge_c};
          cnt <= cnt + 5'd1;
          if (cnt == 5'(ITERS - 1)) begin
            state <= FIX;
          end
        end
        FIX: begin
          if (dz_pend) begin
            Q_NUM <= 16'hFFFF;
            R_NUM <= a_lo;
            dz    <= 1'b1;
            ovf   <= 1'b0;
          end else begin
            dz <= 1'b0;
`ifdef DIV_SAT_EN
            if (ovf_c) begin
              Q_NUM <= 16'h7FFF;
              R_NUM <= 8'd0;
              ovf   <= 1'b1;
            end else begin
              Q_NUM <= sign_q ? q_neg_c : dvd;
              R_NUM <= sign_r ? r_neg_c : rem;
              ovf   <= 1'b0;
            end
`else
            // Overflow wraps naturally: magnitude 32768 reads back as 16'h8000
            Q_NUM <= sign_q ? q_neg_c : dvd;
            R_NUM <= sign_r ? r_neg_c : rem;
            ovf   <= 1'b0;
`endif
          end
          done  <= 1'b1;
          busy  <= 1'b0;
          cnt   <= '0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_16_8_seq.sv
// tb_div_16_8_seq: vector table, corner sequences and randomized checks against
// an integer-arithmetic reference model. Honors DIV_SAT_EN like the design.
module tb_div_16_8_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] A_NUM;
  logic [7:0]  B_NUM;
  logic [15:0] Q_NUM;
  logic [7:0]  R_NUM;
  logic        busy;
  logic        done;
  logic        dz;
  logic        ovf;

  int checks;
  int errors;

`ifdef DIV_SAT_EN
  localparam logic [15:0] OVF_Q = 16'h7FFF;
  localparam logic        OVF_F = 1'b1;
`else
  localparam logic [15:0] OVF_Q = 16'h8000;
  localparam logic        OVF_F = 1'b0;
`endif

  typedef struct {
    logic [15:0] a;
    logic [7:0]  b;
    logic [15:0] q;
    logic [7:0]  r;
    logic        dz;
    logic        ovf;
    int          lat;
    int          bcyc;
  } vec_t;

  div_16_8_seq dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A_NUM (A_NUM),
    .B_NUM (B_NUM),
    .Q_NUM (Q_NUM),
    .R_NUM (R_NUM),
    .busy  (busy),
    .done  (done),
    .dz    (dz),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: signed integer division, truncating, remainder sign of dividend
  function automatic logic [25:0] model(input logic [15:0] a, input logic [7:0] b);
    int ai;
    int bi;
    int qi;
    int ri;
    ai = int'($signed(a));
    bi = int'($signed(b));
    if (bi == 0) return {16'hFFFF, a[7:0], 1'b1, 1'b0};
    if (ai == -32768 && bi == -1) return {OVF_Q, 8'h00, 1'b0, OVF_F};
    qi = ai / bi;
    ri = ai % bi;
    return {16'(qi), 8'(ri), 1'b0, 1'b0};
  endfunction

  // Issue one start pulse; return latency to done and number of busy cycles
  task automatic go(input logic [15:0] a, input logic [7:0] b, output int lat, output int bcyc);
    A_NUM = a;
    B_NUM = b;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    bcyc = busy ? 1 : 0;
    lat  = 0;
    while (!done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (busy) bcyc++;
    end
  endtask

  task automatic check_model(input string name, input logic [15:0] a, input logic [7:0] b, input int lat);
    logic [25:0] e;
    e = model(a, b);
    chk({name, ".q"},   32'(Q_NUM), 32'(e[25:10]));
    chk({name, ".r"},   32'(R_NUM), 32'(e[9:2]));
    chk({name, ".dz"},  32'(dz),    32'(e[1]));
    chk({name, ".ovf"}, 32'(ovf),   32'(e[0]));
    chk({name, ".lat"}, 32'(lat),   (b == 8'd0) ? 32'd1 : 32'd17);
  endtask

  initial begin
    vec_t tbl[9];
    int lat;
    int bcyc;
    logic [15:0] ra;
    logic [7:0]  rb;

    checks = 0;
    errors = 0;
    rst    = 1'b1;
    start  = 1'b0;
    A_NUM  = '0;
    B_NUM  = '0;

    tbl[0] = '{16'd1000,   8'd7,    16'h008E, 8'h06, 1'b0, 1'b0,  17, 17};
    tbl[1] = '{16'hFC18,   8'd7,    16'hFF72, 8'hFA, 1'b0, 1'b0,  17, 17};
    tbl[2] = '{16'd1000,   8'hF9,   16'hFF72, 8'h06, 1'b0, 1'b0,  17, 17};
    tbl[3] = '{16'h8000,   8'h80,   16'h0100, 8'h00, 1'b0, 1'b0,  17, 17};
    tbl[4] = '{16'd1000,   8'h00,   16'hFFFF, 8'hE8, 1'b1, 1'b0,  1,  1};
    tbl[5] = '{16'd1000,   8'd7,    16'h008E, 8'h06, 1'b0, 1'b0,  17, 17};
    tbl[6] = '{16'h8000,   8'hFF,   OVF_Q,    8'h00, 1'b0, OVF_F, 17, 17};
    tbl[7] = '{16'd50,     8'd3,    16'd16,   8'd2,  1'b0, 1'b0,  17, 17};
    tbl[8] = '{16'h8000,   8'h01,   16'h8000, 8'h00, 1'b0, 1'b0,  17, 17};

    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", {7'd0, Q_NUM, R_NUM, busy, done, dz, ovf}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Table vectors, issued back to back
    for (int i = 0; i < 9; i++) begin
      go(tbl[i].a, tbl[i].b, lat, bcyc);
      chk($sformatf("tbl%0d.q", i),    32'(Q_NUM), 32'(tbl[i].q));
      chk($sformatf("tbl%0d.r", i),    32'(R_NUM), 32'(tbl[i].r));
      chk($sformatf("tbl%0d.dz", i),   32'(dz),    32'(tbl[i].dz));
      chk($sformatf("tbl%0d.ovf", i),  32'(ovf),   32'(tbl[i].ovf));
      chk($sformatf("tbl%0d.lat", i),  32'(lat),   32'(tbl[i].lat));
      chk($sformatf("tbl%0d.busy", i), 32'(bcyc),  32'(tbl[i].bcyc));
    end

    // done is a single-cycle pulse and the result holds afterwards
    @(posedge clk); #1;
    chk("done_pulse", 32'(done), 32'd0);
    chk("hold_q", 32'(Q_NUM), 32'h8000);
    repeat (3) @(posedge clk);
    #1;
    chk("hold_idle", {15'd0, Q_NUM, busy}, {15'd0, 16'h8000, 1'b0});

    // start while busy is ignored; inputs change after accept
    A_NUM = 16'd100;
    B_NUM = 8'd3;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    while (!done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (lat == 4) begin
        A_NUM = 16'd9;
        B_NUM = 8'd9;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
    end
    chk("ign.q",   32'(Q_NUM), 32'd33);
    chk("ign.r",   32'(R_NUM), 32'd1);
    chk("ign.lat", 32'(lat),   32'd17);

    // start in the done cycle is accepted
    go(16'd9, 8'd9, lat, bcyc);
    chk("b2b.q",   32'(Q_NUM), 32'd1);
    chk("b2b.r",   32'(R_NUM), 32'd0);
    chk("b2b.lat", 32'(lat),   32'd17);

    // Reset mid-operation abandons the division
    A_NUM = 16'd1000;
    B_NUM = 8'd7;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("midrst_outputs", {7'd0, Q_NUM, R_NUM, busy, done, dz, ovf}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    lat = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (done || busy) lat++;
    end
    chk("midrst_no_done", 32'(lat), 32'd0);
    go(16'd50, 8'hFB, lat, bcyc);
    chk("postrst.q",   32'(Q_NUM), 32'hFFF6);
    chk("postrst.r",   32'(R_NUM), 32'd0);
    chk("postrst.lat", 32'(lat),   32'd17);

    // Randomized operands with biased corner values
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 5))
        0:       ra = 16'h8000;
        1:       ra = 16'h7FFF;
        default: ra = 16'($urandom);
      endcase
      case ($urandom_range(0, 7))
        0:       rb = 8'h00;
        1:       rb = 8'hFF;
        2:       rb = 8'h80;
        3:       rb = 8'h01;
        default: rb = 8'($urandom);
      endcase
      go(ra, rb, lat, bcyc);
      check_model($sformatf("rnd%0d", i), ra, rb, lat);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
